itch_message_framer: RTL and testbench

//  Upstream stage of the ITCH decode path. Consumes a length-prefixed ITCH byte stream and strips the
//  2-byte big-endian length and the 1-byte message-type byte. Packs the remaining body bytes into
//  (DATA_WIDTH+1)-bit words and drives the per-type parsers (add/delete/execute...) with

---
 rtl/itch_message_framer_if.sv | 19 +
 rtl/itch_message_framer.sv | 87 ++++++++
 tb/tb_itch_message_framer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/itch_message_framer_if.sv
// itch_message_framer_if: byte-stream input and per-type parser output bundle of the ITCH framer.
interface itch_message_framer_if #(parameter int DATA_WIDTH = 31);
   logic [7:0] byte_in;
   logic byte_valid_in;
   logic byte_ready_out;
   logic [DATA_WIDTH:0] data_out;
   logic [2:0] mess_type_out;
   logic enable_out;
   logic valid_out;
   logic drop_out;
   modport master (
      input byte_in, byte_valid_in,
      output byte_ready_out, data_out, mess_type_out, enable_out, valid_out, drop_out
   );
   modport slave (
      output byte_in, byte_valid_in,
      input byte_ready_out, data_out, mess_type_out, enable_out, valid_out, drop_out
   );
endinterface

// File: rtl/itch_message_framer.sv
// itch_message_framer: strips the ITCH length/type prefix and packs body bytes into parser words.
module itch_message_framer #(
   parameter int DATA_WIDTH = 31,
   parameter int MAX_LEN = 64,
   parameter int GAP_CYCLES = 1
) (
   input logic clk_in,
   input logic reset_in,
   itch_message_framer_if.master bus
);
   localparam int WB = DATA_WIDTH + 1;
   localparam int W = WB / 8;
   localparam int LW = W > 1 ? $clog2(W) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [2:0] {LEN_HI, LEN_LO, TYPE, BODY, GAP, DROP} state_t;
   state_t state, state_nxt;
   logic [7:0] len_hi;
   logic [15:0] len_full;
   logic [15:0] remaining;
   logic [LW-1:0] lane;
   logic [DATA_WIDTH:0] pack;
   logic [DATA_WIDTH:0] pack_nxt;
   logic [GW-1:0] gap_cnt;
   logic xfer;
   logic last_word;
   function automatic logic [2:0] type_code(input logic [7:0] b);
      return b == "A" ? 3'd0 : b == "F" ? 3'd1 : b == "E" ? 3'd2 : b == "C" ? 3'd3 :
             b == "X" ? 3'd4 : b == "D" ? 3'd5 : b == "U" ? 3'd6 : 3'd7;
   endfunction
   assign xfer = bus.byte_valid_in & bus.byte_ready_out;
   assign len_full = {len_hi, bus.byte_in};
   assign last_word = lane == LW'(W - 1) || remaining == 16'd1;
   assign pack_nxt = pack | (WB'(bus.byte_in) << {lane, 3'b000});
   always_ff @(posedge clk_in or negedge reset_in)
      if (!reset_in) state <= LEN_HI;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         LEN_HI: state_nxt = xfer ? LEN_LO : LEN_HI;
         LEN_LO: if (xfer) state_nxt = len_full == 16'd0 ? LEN_HI : len_full > 16'(MAX_LEN) ? DROP : TYPE;
         TYPE: if (xfer) state_nxt = remaining == 16'd1 ? GAP : BODY;
         BODY: if (xfer && remaining == 16'd1) state_nxt = GAP;
         GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = LEN_HI;
         DROP: if (xfer && remaining == 16'd1) state_nxt = LEN_HI;
         default: state_nxt = LEN_HI;
      endcase
   end
   // Ready is registered from the next state so it is already low on the first gap cycle.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         bus.byte_ready_out <= 1'b0;
         bus.data_out <= '0;
         bus.mess_type_out <= 3'd0;
         bus.enable_out <= 1'b0;
         bus.valid_out <= 1'b0;
         bus.drop_out <= 1'b0;
         len_hi <= 8'd0;
         remaining <= 16'd0;
         lane <= '0;
         pack <= '0;
         gap_cnt <= '0;
      end else begin
         bus.byte_ready_out <= state_nxt != GAP;
         bus.valid_out <= 1'b0;
         bus.drop_out <= 1'b0;
         if (xfer && state == LEN_HI) len_hi <= bus.byte_in;
         if (xfer && state == LEN_LO) remaining <= len_full;
         if (xfer && (state == TYPE || state == BODY || state == DROP)) remaining <= remaining - 16'd1;
         if (xfer && state == TYPE) begin
            bus.mess_type_out <= type_code(bus.byte_in);
            bus.enable_out <= 1'b1;
         end
         if (xfer && state == BODY) begin
            pack <= last_word ? '0 : pack_nxt;
            lane <= last_word ? '0 : lane + LW'(1);
            if (last_word) bus.data_out <= pack_nxt;
            bus.valid_out <= last_word;
         end
         if (xfer && state == DROP && remaining == 16'd1) bus.drop_out <= 1'b1;
         if (state == GAP) begin
            bus.enable_out <= 1'b0;
            gap_cnt <= state_nxt == GAP ? gap_cnt + GW'(1) : '0;
         end
      end
   end
endmodule

// File: tb/tb_itch_message_framer.sv
// tb_itch_message_framer: randomized and directed checks of the framer against a message-level model.
module tb_itch_message_framer;
   localparam int DW = 31;
   localparam int W = (DW + 1) / 8;
   localparam int MAX_LEN = 64;
   localparam int GAP = 1;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int errors = 0;
   itch_message_framer_if #(.DATA_WIDTH(DW)) bus ();
   itch_message_framer #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
      .clk_in(clk), .reset_in(reset_n), .bus(bus));
   always #5 clk = ~clk;
   logic [DW:0] got_words[$];
   logic [DW:0] exp_words[$];
   logic [2:0] got_types[$];
   logic [2:0] exp_types[$];
   int got_drops, exp_drops, rises, en_hi, rdy_lo, low_run, min_low, cyc, last_valid_cyc, fall_cyc;
   logic en_prev = 1'b0;
   // Observes the parser side once per cycle, mid-cycle.
   always @(negedge clk) begin
      if (!reset_n) en_prev = 1'b0;
      else begin
         cyc++;
         if (bus.valid_out) begin
            got_words.push_back(bus.data_out);
            last_valid_cyc = cyc;
            checks++;
            if (bus.enable_out !== 1'b1) begin
               errors++;
               $display("FAIL valid_without_enable enable=%0b required=1", bus.enable_out);
            end
         end
         if (bus.drop_out) got_drops++;
         if (bus.enable_out && !en_prev) begin
            rises++;
            got_types.push_back(bus.mess_type_out);
            if (rises > 1 && low_run < min_low) min_low = low_run;
         end
         if (!bus.enable_out && en_prev) fall_cyc = cyc;
         low_run = bus.enable_out ? 0 : low_run + 1;
         if (bus.enable_out) en_hi++;
         if (!bus.byte_ready_out) rdy_lo++;
         en_prev = bus.enable_out;
      end
   end
   function automatic logic [2:0] code_of(input logic [7:0] t);
      string s = "AFECXDU";
      for (int i = 0; i < 7; i++) if (s[i] == t) return 3'(i);
      return 3'd7;
   endfunction
   function automatic void model(input int len, input logic [7:0] t, input logic [7:0] body[$]);
      if (len == 0) return;
      if (len > MAX_LEN) begin
         exp_drops++;
         return;
      end
      exp_types.push_back(code_of(t));
      for (int i = 0; i < len - 1; i += W) begin
         logic [DW:0] w = '0;
         for (int j = 0; j < W && i + j < len - 1; j++) w[8*j +: 8] = body[i+j];
         exp_words.push_back(w);
      end
   endfunction
   task automatic clear();
      @(negedge clk);
      #1;
      got_words.delete(); exp_words.delete(); got_types.delete(); exp_types.delete();
      got_drops = 0; exp_drops = 0; rises = 0; en_hi = 0; rdy_lo = 0; low_run = 0;
      min_low = 1000; last_valid_cyc = -1; fall_cyc = -1;
   endtask
   task automatic idle();
      @(negedge clk);
      bus.byte_valid_in = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      bus.byte_in = b;
      bus.byte_valid_in = 1'b1;
      while (!bus.byte_ready_out && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout ready=%0b required=1", bus.byte_ready_out);
      end
   endtask
   task automatic send_msg(input int len, input logic [7:0] t, input bit seq, input int bubble_pct);
      logic [7:0] body[$];
      for (int i = 0; i < len - 1; i++) body.push_back(seq ? 8'(i + 1) : 8'($urandom));
      model(len, t, body);
      send_byte(8'(len >> 8));
      send_byte(8'(len));
      if (len > 0) send_byte(t);
      foreach (body[i]) begin
         if (int'($urandom_range(99)) < bubble_pct) idle();
         send_byte(body[i]);
      end
   endtask
   task automatic compare_all(input string name);
      idle();
      repeat (12) @(negedge clk);
      #1;
      checks++;
      if (got_words.size() != exp_words.size()) begin
         errors++;
         $display("FAIL %s word_count got=%0d required=%0d", name, got_words.size(), exp_words.size());
      end
      for (int i = 0; i < got_words.size() && i < exp_words.size(); i++) begin
         checks++;
         if (got_words[i] !== exp_words[i]) begin
            errors++;
            $display("FAIL %s word%0d got=%h required=%h", name, i, got_words[i], exp_words[i]);
         end
      end
      checks++;
      if (got_types != exp_types) begin
         errors++;
         $display("FAIL %s types got=%p required=%p", name, got_types, exp_types);
      end
      checks++;
      if (got_drops != exp_drops) begin
         errors++;
         $display("FAIL %s drops got=%0d required=%0d", name, got_drops, exp_drops);
      end
      checks++;
      if (rises != exp_types.size()) begin
         errors++;
         $display("FAIL %s enable_windows got=%0d required=%0d", name, rises, exp_types.size());
      end
   endtask
   task automatic test_reset();
      bus.byte_in = 8'd0;
      bus.byte_valid_in = 1'b0;
      #12;
      checks++;
      if ({bus.enable_out, bus.valid_out, bus.drop_out, bus.byte_ready_out, bus.mess_type_out, bus.data_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs en=%0b v=%0b d=%0b rdy=%0b t=%0d data=%h required=all0",
                  bus.enable_out, bus.valid_out, bus.drop_out, bus.byte_ready_out, bus.mess_type_out, bus.data_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   task automatic test_add();
      clear();
      send_msg(36, "A", 1'b1, 0);
      compare_all("add");
      checks++;
      if (got_words.size() != 9 || got_words[0] !== 32'h04030201 || got_words[8] !== 32'h00232221) begin
         errors++;
         $display("FAIL add_ends got=%p required=9 words 04030201..00232221", got_words);
      end
      checks++;
      if (fall_cyc != last_valid_cyc + 1) begin
         errors++;
         $display("FAIL add_enable_fall got=%0d required=%0d", fall_cyc, last_valid_cyc + 1);
      end
   endtask
   task automatic test_delete_bubbles();
      clear();
      send_msg(19, "D", 1'b1, 100);
      compare_all("delete_bubbles");
      checks++;
      if (got_words.size() != 5 || got_words[4] !== 32'h00001211) begin
         errors++;
         $display("FAIL delete_last got=%p required=5 words ending 00001211", got_words);
      end
   endtask
   task automatic test_drop();
      clear();
      send_msg(80, "A", 1'b0, 0);
      send_msg(36, "A", 1'b0, 0);
      compare_all("drop");
      checks++;
      if (rdy_lo != GAP) begin
         errors++;
         $display("FAIL drop_ready_low got=%0d required=%0d", rdy_lo, GAP);
      end
   endtask
   task automatic test_back_to_back();
      clear();
      send_msg(31, "E", 1'b0, 0);
      send_msg(36, "A", 1'b0, 0);
      compare_all("back_to_back");
      checks++;
      if (min_low < GAP) begin
         errors++;
         $display("FAIL b2b_enable_gap got=%0d required>=%0d", min_low, GAP);
      end
      checks++;
      if (rdy_lo != 2 * GAP) begin
         errors++;
         $display("FAIL b2b_ready_low got=%0d required=%0d", rdy_lo, 2 * GAP);
      end
   endtask
   task automatic test_reset_mid();
      clear();
      send_byte(8'h00);
      send_byte(8'd36);
      send_byte("A");
      for (int i = 1; i <= 20; i++) send_byte(8'(i));
      idle();
      #1;
      checks++;
      if (got_words.size() != 5 || got_words[4] !== 32'h14131211 || bus.enable_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_before_reset got=%p en=%0b required=5 words ending 14131211 en=1", got_words, bus.enable_out);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.enable_out, bus.valid_out, bus.byte_ready_out, bus.mess_type_out, bus.data_out} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs en=%0b v=%0b rdy=%0b t=%0d data=%h required=all0",
                  bus.enable_out, bus.valid_out, bus.byte_ready_out, bus.mess_type_out, bus.data_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      clear();
      send_msg(36, "A", 1'b0, 0);
      compare_all("post_reset_add");
   endtask
   task automatic test_short();
      clear();
      send_msg(1, "X", 1'b0, 0);
      compare_all("len1_X");
      checks++;
      if (en_hi != 1) begin
         errors++;
         $display("FAIL len1_enable_cycles got=%0d required=1", en_hi);
      end
      clear();
      send_msg(0, "A", 1'b0, 0);
      send_msg(1, "C", 1'b0, 0);
      compare_all("len0_then_C");
      checks++;
      if (en_hi != 1) begin
         errors++;
         $display("FAIL len0_enable_cycles got=%0d required=1", en_hi);
      end
   endtask
   task automatic test_random();
      string kinds = "AFECXDUZ";
      clear();
      for (int n = 0; n < 25; n++) begin
         int r = int'($urandom_range(9));
         int len = r == 0 ? 0 : r == 1 ? int'($urandom_range(90, 65)) : int'($urandom_range(MAX_LEN, 1));
         logic [7:0] t = r == 2 ? 8'($urandom) : kinds[$urandom_range(7)];
         send_msg(len, t, 1'b0, int'($urandom_range(50)));
         if (r == 3) idle();
      end
      compare_all("random");
   endtask
   initial begin
      test_reset();
      test_add();
      test_delete_bubbles();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      test_short();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
